// File: rtl/rgb_ycbcr_pkg.sv
// Shared constants, coefficient sets and helpers for the RGB888 -> YCbCr (BT.601 full-range) converter.
package rgb_ycbcr_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned COEF_W   = 9;
    localparam int unsigned PROD_W   = 17;
    localparam int unsigned SUM_W    = 19;
    localparam int unsigned FRAC_DEF = 8;

    localparam int ROUND      = 128;
    localparam int CHROMA_OFS = 128;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic signed [COEF_W-1:0] cr;
        logic signed [COEF_W-1:0] cg;
        logic signed [COEF_W-1:0] cb;
    } coef3_t;

    localparam coef3_t COEF_Y  = '{cr: 9'sd77,   cg: 9'sd150,  cb: 9'sd29};
    localparam coef3_t COEF_CB = '{cr: -9'sd43,  cg: -9'sd85,  cb: 9'sd128};
    localparam coef3_t COEF_CR = '{cr: 9'sd128,  cg: -9'sd107, cb: -9'sd21};

    // Saturate a signed intermediate to the unsigned 8-bit pixel range.
    function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [SUM_W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > 255)
            return 8'd255;
        else
            return PIX_W'(v);
    endfunction

endpackage

// File: rtl/ycbcr_mac3.sv
// One output channel: 3 products (S1), sum + round (S2), shift/offset/clamp (S3 output register).
module ycbcr_mac3
    import rgb_ycbcr_pkg::*;
#(
    parameter coef3_t      COEF = COEF_Y,
    parameter int          OFS  = 0,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en1,
    input  logic             en2,
    input  logic             en3,
    input  rgb_t             pix,
    output logic [PIX_W-1:0] q
);

    logic signed [PROD_W-1:0] p_r, p_g, p_b;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [SUM_W-1:0]  shifted_c;
    logic signed [SUM_W-1:0]  scaled_c;

    always_comb begin
        sum_c     = SUM_W'(p_r) + SUM_W'(p_g) + SUM_W'(p_b) + SUM_W'(ROUND);
        shifted_c = sum >>> FRAC;
        scaled_c  = shifted_c + SUM_W'(OFS);
    end

    // Each stage loads only when its incoming valid is set, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r <= '0;
            p_g <= '0;
            p_b <= '0;
            sum <= '0;
            q   <= '0;
        end else begin
            if (en1) begin
                p_r <= PROD_W'(COEF.cr) * PROD_W'($signed({1'b0, pix.r}));
                p_g <= PROD_W'(COEF.cg) * PROD_W'($signed({1'b0, pix.g}));
                p_b <= PROD_W'(COEF.cb) * PROD_W'($signed({1'b0, pix.b}));
            end
            if (en2)
                sum <= sum_c;
            if (en3)
                q <= clamp_u8(scaled_c);
        end
    end

endmodule

// File: rtl/rgb_ycbcr_source.sv
// Pipelined RGB888 -> YCbCr source, 3-cycle latency, 1 pixel/cycle.
// Define RGB_YCBCR_POS_EN to enable line/frame position tagging on eol/eof.
module rgb_ycbcr_source
    import rgb_ycbcr_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned FRAC       = FRAC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [PIX_W-1:0] R,
    input  logic [PIX_W-1:0] G,
    input  logic [PIX_W-1:0] B,
    output logic             valid_out,
    output logic [PIX_W-1:0] Y,
    output logic [PIX_W-1:0] Cb,
    output logic [PIX_W-1:0] Cr,
    output logic             eol,
    output logic             eof
);

    if (IMG_WIDTH == 0 || IMG_HEIGHT == 0) begin : g_bad_cfg
        $error("rgb_ycbcr_source: image dimensions must be non-zero");
    end

    logic v1, v2;
    rgb_t pix;

    assign pix = '{r: R, g: G, b: B};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            v1        <= valid_in;
            v2        <= v1;
            valid_out <= v2;
        end
    end

    ycbcr_mac3 #(.COEF(COEF_Y),  .OFS(0),          .FRAC(FRAC)) u_y (
        .clk(clk), .rst(rst), .en1(valid_in), .en2(v1), .en3(v2), .pix(pix), .q(Y)
    );

    ycbcr_mac3 #(.COEF(COEF_CB), .OFS(CHROMA_OFS), .FRAC(FRAC)) u_cb (
        .clk(clk), .rst(rst), .en1(valid_in), .en2(v1), .en3(v2), .pix(pix), .q(Cb)
    );

    ycbcr_mac3 #(.COEF(COEF_CR), .OFS(CHROMA_OFS), .FRAC(FRAC)) u_cr (
        .clk(clk), .rst(rst), .en1(valid_in), .en2(v1), .en3(v2), .pix(pix), .q(Cr)
    );

`ifdef RGB_YCBCR_POS_EN
    localparam int unsigned XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_end_c, frame_end_c;
    logic          eol1, eof1, eol2, eof2;

    always_comb begin
        line_end_c  = (x == XW'(IMG_WIDTH - 1));
        frame_end_c = line_end_c && (y == YW'(IMG_HEIGHT - 1));
    end

    // Position flags are captured with the pixel at S1 and ride along with the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            eol1 <= 1'b0;
            eof1 <= 1'b0;
            eol2 <= 1'b0;
            eof2 <= 1'b0;
            eol  <= 1'b0;
            eof  <= 1'b0;
        end else begin
            if (valid_in) begin
                eol1 <= line_end_c;
                eof1 <= frame_end_c;
                if (line_end_c) begin
                    x <= '0;
                    y <= frame_end_c ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
            if (v1) begin
                eol2 <= eol1;
                eof2 <= eof1;
            end
            eol <= v2 & eol2;
            eof <= v2 & eof2;
        end
    end
`else
    assign eol = 1'b0;
    assign eof = 1'b0;
`endif

endmodule
